// File: rtl/seg7_pkg.sv
// Shared types and constants for the two-digit multiplexed seven-segment scanner.
package seg7_pkg;

    typedef enum logic [1:0] {
        S_ONES = 2'd0,
        S_GAP1 = 2'd1,
        S_TENS = 2'd2,
        S_GAP0 = 2'd3
    } scan_state_e;

    // Wide enough to hold SCAN_DIV-1 at the largest legal SCAN_DIV (2^20).
    localparam int DWELL_W = 20;

    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [1:0] AN_OFF    = 2'b11;
    localparam logic [1:0] AN_ONES   = 2'b10;
    localparam logic [1:0] AN_TENS   = 2'b01;

    localparam logic [6:0] SEG_DIG_0 = 7'h40;
    localparam logic [6:0] SEG_DIG_1 = 7'h79;
    localparam logic [6:0] SEG_DIG_2 = 7'h24;
    localparam logic [6:0] SEG_DIG_3 = 7'h30;
    localparam logic [6:0] SEG_DIG_4 = 7'h19;
    localparam logic [6:0] SEG_DIG_5 = 7'h12;
    localparam logic [6:0] SEG_DIG_6 = 7'h02;
    localparam logic [6:0] SEG_DIG_7 = 7'h78;
    localparam logic [6:0] SEG_DIG_8 = 7'h00;
    localparam logic [6:0] SEG_DIG_9 = 7'h10;

endpackage

// File: rtl/seg7_decode.sv
// Combinational BCD digit to active-low {g,f,e,d,c,b,a} segment pattern.
module seg7_decode
    import seg7_pkg::*;
(
    input  logic [3:0] digit,
    output logic [6:0] seg
);

    // Codes above 9 never reach here in normal operation; blank them defensively.
    always_comb begin
        seg = SEG_BLANK;
        case (digit)
            4'd0:    seg = SEG_DIG_0;
            4'd1:    seg = SEG_DIG_1;
            4'd2:    seg = SEG_DIG_2;
            4'd3:    seg = SEG_DIG_3;
            4'd4:    seg = SEG_DIG_4;
            4'd5:    seg = SEG_DIG_5;
            4'd6:    seg = SEG_DIG_6;
            4'd7:    seg = SEG_DIG_7;
            4'd8:    seg = SEG_DIG_8;
            4'd9:    seg = SEG_DIG_9;
            default: seg = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/seg7_scan.sv
// Two-digit multiplexed display scanner for a 0..15 count, with blank gaps between digits.
// Optional macro SEG7_LZB_EN blanks the tens digit when it is zero.
module seg7_scan
    import seg7_pkg::*;
#(
    parameter int SCAN_DIV = 50000,
    parameter int GAP_CYC  = 2
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic [3:0] IN,
    input  logic       LOAD,
    output logic [6:0] SEG,
    output logic [1:0] AN,
    output logic       FRAME
);

    localparam logic [DWELL_W-1:0] SCAN_LAST = DWELL_W'(SCAN_DIV - 1);
    localparam logic [DWELL_W-1:0] GAP_LAST  = DWELL_W'(GAP_CYC - 1);

    scan_state_e        state_q, state_d;
    logic [DWELL_W-1:0] dwell_q, dwell_d;
    logic [3:0]         pend_q, pend_d;
    logic [3:0]         disp_q, disp_d;
    logic [6:0]         seg_q, seg_d;
    logic [1:0]         an_q, an_d;
    logic               frame_q, frame_d;

    logic               dwell_done;
    logic               tens;
    logic [3:0]         ones;
    logic [3:0]         digit_sel;
    logic [6:0]         seg_dec;

    always_comb begin
        state_d = state_q;
        dwell_d = dwell_q + DWELL_W'(1);
        pend_d  = LOAD ? IN : pend_q;
        disp_d  = disp_q;

        if (state_q == S_ONES || state_q == S_TENS) begin
            dwell_done = (dwell_q == SCAN_LAST);
        end else begin
            dwell_done = (dwell_q == GAP_LAST);
        end

        // The display value latches the pending value present before this edge's LOAD.
        if (dwell_done) begin
            dwell_d = '0;
            case (state_q)
                S_ONES:  state_d = S_GAP1;
                S_GAP1:  state_d = S_TENS;
                S_TENS:  state_d = S_GAP0;
                S_GAP0: begin
                    state_d = S_ONES;
                    disp_d  = pend_q;
                end
                default: state_d = S_ONES;
            endcase
        end
    end

    assign tens      = (disp_q >= 4'd10);
    assign ones      = tens ? (disp_q - 4'd10) : disp_q;
    assign digit_sel = (state_q == S_TENS) ? {3'b000, tens} : ones;

    seg7_decode u_decode (
        .digit (digit_sel),
        .seg   (seg_dec)
    );

    always_comb begin
        an_d    = AN_OFF;
        seg_d   = SEG_BLANK;
        frame_d = (state_q == S_ONES) && (dwell_q == '0);
        case (state_q)
            S_ONES: begin
                an_d  = AN_ONES;
                seg_d = seg_dec;
            end
            S_TENS: begin
`ifdef SEG7_LZB_EN
                if (tens) begin
                    an_d  = AN_TENS;
                    seg_d = seg_dec;
                end
`else
                an_d  = AN_TENS;
                seg_d = seg_dec;
`endif
            end
            default: begin
                an_d  = AN_OFF;
                seg_d = SEG_BLANK;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RST) begin
            state_q <= S_ONES;
            dwell_q <= '0;
            pend_q  <= '0;
            disp_q  <= '0;
            seg_q   <= SEG_BLANK;
            an_q    <= AN_OFF;
            frame_q <= 1'b0;
        end else begin
            state_q <= state_d;
            dwell_q <= dwell_d;
            pend_q  <= pend_d;
            disp_q  <= disp_d;
            seg_q   <= seg_d;
            an_q    <= an_d;
            frame_q <= frame_d;
        end
    end

    assign SEG   = seg_q;
    assign AN    = an_q;
    assign FRAME = frame_q;

endmodule

// File: tb/tb_seg7_scan.sv
// Randomized self-checking bench for seg7_scan (SCAN_DIV=4, GAP_CYC=2, 12-cycle frame).
module tb_seg7_scan;

    localparam int SCAN_DIV = 4;
    localparam int GAP_CYC  = 2;
    localparam int FRAME_LEN = 2 * SCAN_DIV + 2 * GAP_CYC;

    logic       CLK = 1'b0;
    logic       RST;
    logic [3:0] IN;
    logic       LOAD;
    logic [6:0] SEG;
    logic [1:0] AN;
    logic       FRAME;

    int vectors     = 0;
    int miscompares = 0;

    logic [6:0] dec_tab [10];
    int m_pend, m_staged, m_shown, m_edge;
    logic [6:0] exp_seg;
    logic [1:0] exp_an;
    logic       exp_frame;

    int chk_an_both   = 0;
    int chk_bad_per   = 0;
    int chk_periods   = 0;
    int per_cycles    = 0;
    bit period_valid  = 0;

    seg7_scan #(.SCAN_DIV(SCAN_DIV), .GAP_CYC(GAP_CYC)) dut (
        .CLK   (CLK),
        .RST   (RST),
        .IN    (IN),
        .LOAD  (LOAD),
        .SEG   (SEG),
        .AN    (AN),
        .FRAME (FRAME)
    );

    always #5 CLK = ~CLK;

    // Independent watch on digit overlap and frame spacing across every scenario.
    always @(negedge CLK) begin
        if (AN === 2'b00) chk_an_both++;
        per_cycles++;
        if (FRAME === 1'b1) begin
            if (period_valid) begin
                chk_periods++;
                if (per_cycles != FRAME_LEN) chk_bad_per++;
            end
            per_cycles   = 0;
            period_valid = 1;
        end
    end

    // Reference: expected outputs follow from the position inside the frame since reset release.
    task automatic tick(input logic rst_v, input logic load_v, input logic [3:0] in_v);
        int pos, t, o;
        RST  = rst_v;
        LOAD = load_v;
        IN   = in_v;
        @(posedge CLK);
        if (!rst_v) begin
            m_pend = 0; m_staged = 0; m_shown = 0; m_edge = 0;
            exp_seg = 7'h7F; exp_an = 2'b11; exp_frame = 1'b0;
            period_valid = 0;
        end else begin
            pos = m_edge % FRAME_LEN;
            if (pos == 0) m_shown = m_staged;
            t = m_shown / 10;
            o = m_shown % 10;
            exp_frame = (pos == 0);
            exp_seg = 7'h7F;
            exp_an  = 2'b11;
            if (pos < SCAN_DIV) begin
                exp_an = 2'b10; exp_seg = dec_tab[o];
            end else if (pos >= SCAN_DIV + GAP_CYC && pos < 2 * SCAN_DIV + GAP_CYC) begin
`ifdef SEG7_LZB_EN
                if (t != 0) begin
                    exp_an = 2'b01; exp_seg = dec_tab[t];
                end
`else
                exp_an = 2'b01; exp_seg = dec_tab[t];
`endif
            end
            if (pos == FRAME_LEN - 1) m_staged = m_pend;
            if (load_v) m_pend = int'(in_v);
            m_edge++;
        end
        #1;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 3; i++) begin
            tick(1'b0, 1'b1, 4'($urandom_range(15)));
            vectors++;
            if (SEG !== 7'h7F || AN !== 2'b11 || FRAME !== 1'b0) begin
                miscompares++;
                $display("[TB] FAIL reset_hold: got SEG=%h AN=%b FRAME=%b want SEG=7f AN=11 FRAME=0", SEG, AN, FRAME);
            end
        end
        tick(1'b1, 1'b0, 4'd0);
        vectors++;
        if (SEG !== 7'h40 || AN !== 2'b10 || FRAME !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL reset_release: got SEG=%h AN=%b FRAME=%b want SEG=40 AN=10 FRAME=1", SEG, AN, FRAME);
        end
    endtask

    task automatic test_idle_frames();
        for (int i = 0; i < 2 * FRAME_LEN; i++) begin
            tick(1'b1, 1'b0, 4'($urandom_range(15)));
            vectors++;
            if (SEG !== exp_seg || AN !== exp_an || FRAME !== exp_frame) begin
                miscompares++;
                $display("[TB] FAIL idle e%0d: got SEG=%h AN=%b FRAME=%b want SEG=%h AN=%b FRAME=%b",
                         m_edge, SEG, AN, FRAME, exp_seg, exp_an, exp_frame);
            end
        end
    endtask

    task automatic test_load_mid_frame();
        for (int i = 0; i < 3 * FRAME_LEN; i++) begin
            tick(1'b1, (i == 3), 4'd13);
            vectors++;
            if (SEG !== exp_seg || AN !== exp_an || FRAME !== exp_frame) begin
                miscompares++;
                $display("[TB] FAIL load13 e%0d: got SEG=%h AN=%b FRAME=%b want SEG=%h AN=%b FRAME=%b",
                         m_edge, SEG, AN, FRAME, exp_seg, exp_an, exp_frame);
            end
        end
    endtask

    task automatic test_double_load();
        logic       ld;
        logic [3:0] v;
        int         n;
        n = 0;
        for (int i = 0; i < 3 * FRAME_LEN; i++) begin
            ld = 1'b0; v = 4'd0;
            if (n < 2 && (m_edge % FRAME_LEN) == 2 + 4 * n) begin
                ld = 1'b1; v = (n == 0) ? 4'd5 : 4'd9; n++;
            end
            tick(1'b1, ld, v);
            vectors++;
            if (SEG !== exp_seg || AN !== exp_an || FRAME !== exp_frame) begin
                miscompares++;
                $display("[TB] FAIL load5_9 e%0d: got SEG=%h AN=%b FRAME=%b want SEG=%h AN=%b FRAME=%b",
                         m_edge, SEG, AN, FRAME, exp_seg, exp_an, exp_frame);
            end
        end
    endtask

    task automatic test_load_on_boundary();
        logic ld;
        bit   done;
        done = 0;
        for (int i = 0; i < 4 * FRAME_LEN; i++) begin
            ld = !done && (m_edge % FRAME_LEN) == FRAME_LEN - 1;
            if (ld) done = 1;
            tick(1'b1, ld, 4'd7);
            vectors++;
            if (SEG !== exp_seg || AN !== exp_an || FRAME !== exp_frame) begin
                miscompares++;
                $display("[TB] FAIL load7_edge e%0d: got SEG=%h AN=%b FRAME=%b want SEG=%h AN=%b FRAME=%b",
                         m_edge, SEG, AN, FRAME, exp_seg, exp_an, exp_frame);
            end
        end
    endtask

    task automatic test_reset_mid_tens();
        bit reached;
        reached = 0;
        for (int i = 0; i < 4 * FRAME_LEN && !reached; i++) begin
            tick(1'b1, (i == 0), 4'd15);
            vectors++;
            if (SEG !== exp_seg || AN !== exp_an || FRAME !== exp_frame) begin
                miscompares++;
                $display("[TB] FAIL pre_rst15 e%0d: got SEG=%h AN=%b FRAME=%b want SEG=%h AN=%b FRAME=%b",
                         m_edge, SEG, AN, FRAME, exp_seg, exp_an, exp_frame);
            end
            if (m_shown == 15 && (m_edge % FRAME_LEN) == SCAN_DIV + GAP_CYC + 1) reached = 1;
        end
        vectors++;
        if (!reached) begin
            miscompares++;
            $display("[TB] FAIL reach_tens15: got reached=0 want reached=1");
        end
        tick(1'b0, 1'b1, 4'd3);
        vectors++;
        if (SEG !== 7'h7F || AN !== 2'b11 || FRAME !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL rst_mid_tens: got SEG=%h AN=%b FRAME=%b want SEG=7f AN=11 FRAME=0", SEG, AN, FRAME);
        end
        for (int i = 0; i < 2 * FRAME_LEN; i++) begin
            tick(1'b1, 1'b0, 4'd0);
            vectors++;
            if (SEG !== exp_seg || AN !== exp_an || FRAME !== exp_frame) begin
                miscompares++;
                $display("[TB] FAIL post_rst e%0d: got SEG=%h AN=%b FRAME=%b want SEG=%h AN=%b FRAME=%b",
                         m_edge, SEG, AN, FRAME, exp_seg, exp_an, exp_frame);
            end
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            tick(($urandom_range(99) != 0), ($urandom_range(3) == 0), 4'($urandom_range(15)));
            vectors++;
            if (SEG !== exp_seg || AN !== exp_an || FRAME !== exp_frame) begin
                miscompares++;
                $display("[TB] FAIL random e%0d: got SEG=%h AN=%b FRAME=%b want SEG=%h AN=%b FRAME=%b",
                         m_edge, SEG, AN, FRAME, exp_seg, exp_an, exp_frame);
            end
        end
    endtask

    task automatic test_invariants();
        vectors++;
        if (chk_an_both !== 0) begin
            miscompares++;
            $display("[TB] FAIL an_overlap: got %0d cycles with AN=00 want 0", chk_an_both);
        end
        vectors++;
        if (chk_bad_per !== 0) begin
            miscompares++;
            $display("[TB] FAIL frame_period: got %0d bad periods want 0", chk_bad_per);
        end
        vectors++;
        if (chk_periods < 10) begin
            miscompares++;
            $display("[TB] FAIL period_count: got %0d measured periods want >=10", chk_periods);
        end
    endtask

    initial begin
        dec_tab[0] = 7'h40; dec_tab[1] = 7'h79; dec_tab[2] = 7'h24; dec_tab[3] = 7'h30;
        dec_tab[4] = 7'h19; dec_tab[5] = 7'h12; dec_tab[6] = 7'h02; dec_tab[7] = 7'h78;
        dec_tab[8] = 7'h00; dec_tab[9] = 7'h10;
        RST = 1'b0; LOAD = 1'b0; IN = 4'd0;
        m_pend = 0; m_staged = 0; m_shown = 0; m_edge = 0;
        test_reset();
        test_idle_frames();
        test_load_mid_frame();
        test_double_load();
        test_load_on_boundary();
        test_reset_mid_tens();
        test_random();
        test_invariants();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
